// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the radix-4 Booth multiplier family.
//   booth_state_e  : control state of the sequential multiplier
//   PP_*           : 3-bit partial-product selection codes from Booth recoding
//   booth_iter()   : iteration count (multiplier bits retired two per cycle)
//   booth_recode() : maps a 3-bit multiplier window to a PP_* code
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  localparam logic [2:0] PP_ZERO = 3'd0;
  localparam logic [2:0] PP_POS1 = 3'd1;
  localparam logic [2:0] PP_POS2 = 3'd2;
  localparam logic [2:0] PP_NEG1 = 3'd3;
  localparam logic [2:0] PP_NEG2 = 3'd4;

  function automatic int booth_iter(input int width);
    return width / 2;
  endfunction

  // Window is {q[i+1], q[i], q[i-1]}; the selected multiple of M is added.
  function automatic logic [2:0] booth_recode(input logic [2:0] win);
    logic [2:0] sel;
    case (win)
      3'b000, 3'b111: sel = PP_ZERO;
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      3'b101, 3'b110: sel = PP_NEG1;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: combinational radix-4 Booth partial-product generator.
// Ports:
//   window [2:0]     : multiplier window {q[1], q[0], q_m1}
//   m      [PP_W-1:0]: sign-/zero-extended multiplicand
//   pp     [PP_W-1:0]: selected partial product (0, +-M, +-2M), wraps in PP_W bits
// PP_W must leave one spare bit over the operand width so that +-2M fits.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int PP_W = 10
) (
  input  logic [2:0]      window,
  input  logic [PP_W-1:0] m,
  output logic [PP_W-1:0] pp
);

  logic [2:0]      sel_s;
  logic [PP_W-1:0] m2_s;

  // Select the partial product for the current window.
  always_comb begin
    sel_s = booth_recode(window);
    m2_s  = {m[PP_W-2:0], 1'b0};
    case (sel_s)
      PP_ZERO: pp = {PP_W{1'b0}};
      PP_POS1: pp = m;
      PP_POS2: pp = m2_s;
      PP_NEG1: pp = {PP_W{1'b0}} - m;
      PP_NEG2: pp = {PP_W{1'b0}} - m2_s;
      default: pp = {PP_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential signed multiplier, radix-4 Booth, two
// multiplier bits retired per cycle (WIDTH/2 iterations).
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only while IDLE)
//   X, Y [WIDTH-1:0]     : multiplicand / multiplier, two's complement
//   is_signed            : only with BOOTH_UNSIGNED_EN; 0 selects unsigned operands
//   out_valid / out_ready: product handshake, Z held while stalled
//   Z [2*WIDTH-1:0]      : product
//   busy                 : high while CALC or DONE
// Optional feature macro: BOOTH_UNSIGNED_EN (adds is_signed and one extra
// iteration for unsigned operations).
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 is_signed,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy
);

  localparam int ITER = booth_iter(WIDTH);
  localparam int AW   = WIDTH + 2;
`ifdef BOOTH_UNSIGNED_EN
  // Q carries the two extension bits so the extra iteration can consume them.
  localparam int QW       = WIDTH + 2;
  localparam int MAX_ITER = ITER + 1;
`else
  localparam int QW       = WIDTH;
  localparam int MAX_ITER = ITER;
`endif
  localparam int CW = $clog2(MAX_ITER + 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("booth_radix4_mult: WIDTH must be even and >= 4");
  end

  booth_state_e       state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [QW-1:0]      q_q, q_d;
  logic               q_m1_q, q_m1_d;
  logic [AW-1:0]      m_q, m_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
`ifdef BOOTH_UNSIGNED_EN
  logic               uns_q, uns_d;
`endif

  logic [AW-1:0]      pp_s;
  logic [AW-1:0]      a_sum_s;
  logic [AW-1:0]      a_sh_s;
  logic [QW-1:0]      q_sh_s;
  logic [2*WIDTH-1:0] z_final_s;
  logic [CW-1:0]      last_iter_s;
  logic               out_fire_s;

  booth_r4_recoder #(
    .PP_W(AW)
  ) u_recoder (
    .window({q_q[1:0], q_m1_q}),
    .m     (m_q),
    .pp    (pp_s)
  );

  // One Booth step: accumulate, then arithmetic shift of {A,Q,q_m1} by two.
  always_comb begin
    a_sum_s = a_q + pp_s;
    a_sh_s  = {{2{a_sum_s[AW-1]}}, a_sum_s[AW-1:2]};
    q_sh_s  = {a_sum_s[1:0], q_q[QW-1:2]};
`ifdef BOOTH_UNSIGNED_EN
    // Signed runs stop with the two extension bits still at the bottom of Q.
    if (uns_q) begin
      z_final_s   = {a_sh_s[WIDTH-3:0], q_sh_s};
      last_iter_s = CW'(ITER);
    end else begin
      z_final_s   = {a_sh_s[WIDTH-1:0], q_sh_s[QW-1:2]};
      last_iter_s = CW'(ITER - 1);
    end
`else
    z_final_s   = {a_sh_s[WIDTH-1:0], q_sh_s};
    last_iter_s = CW'(ITER - 1);
`endif
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    q_m1_d   = q_m1_q;
    m_d      = m_q;
    count_d  = count_q;
    z_d      = z_q;
`ifdef BOOTH_UNSIGNED_EN
    uns_d    = uns_q;
`endif
    out_fire_s = out_valid_q & out_ready;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {AW{1'b0}};
          q_m1_d  = 1'b0;
          count_d = {CW{1'b0}};
`ifdef BOOTH_UNSIGNED_EN
          uns_d = ~is_signed;
          if (is_signed) begin
            m_d = {{2{X[WIDTH-1]}}, X};
            q_d = {{2{Y[WIDTH-1]}}, Y};
          end else begin
            m_d = {2'b00, X};
            q_d = {2'b00, Y};
          end
`else
          m_d = {{2{X[WIDTH-1]}}, X};
          q_d = Y;
`endif
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        a_d     = a_sh_s;
        q_d     = q_sh_s;
        q_m1_d  = q_q[1];
        count_d = count_q + CW'(1);
        if (count_q == last_iter_s) begin
          z_d     = z_final_s;
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // out_valid follows DONE by one edge and drops on the accepting edge.
    out_valid_d = (state_q == DONE) & ~out_fire_s;
    busy_d      = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= {AW{1'b0}};
      q_q         <= {QW{1'b0}};
      q_m1_q      <= 1'b0;
      m_q         <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      z_q         <= {(2*WIDTH){1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef BOOTH_UNSIGNED_EN
      uns_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      q_m1_q      <= q_m1_d;
      m_q         <= m_d;
      count_q     <= count_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef BOOTH_UNSIGNED_EN
      uns_q       <= uns_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Z         = z_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult: directed cases plus a random
// sweep on WIDTH=8 and WIDTH=16 instances, checked by queue scoreboards.
module tb_booth_radix4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;
  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] x16, y16;
  logic [31:0] z16;
`ifdef BOOTH_UNSIGNED_EN
  logic        is_signed8, is_signed16;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int outs8    = 0;
  int outs16   = 0;
  logic [15:0] exp8[$];
  logic [31:0] exp16[$];

  booth_radix4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .X(x8), .Y(y8),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(is_signed8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .Z(z8), .busy(busy8)
  );

  booth_radix4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .X(x16), .Y(y16),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(is_signed16),
`endif
    .out_valid(out_valid16), .out_ready(out_ready16), .Z(z16), .busy(busy16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    longint pa, pb, p;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    longint pa, pb, p;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return p[31:0];
  endfunction

  // Scoreboard monitors: compare each delivered product with the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid8 && out_ready8) begin
      outs8++;
      check("queue8_has_entry", 32'(exp8.size() != 0), 32'd1);
      if (exp8.size() != 0) check("z8", 32'(z8), 32'(exp8.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      outs16++;
      check("queue16_has_entry", 32'(exp16.size() != 0), 32'd1);
      if (exp16.size() != 0) check("z16", z16, exp16.pop_front());
    end
  end

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
    int t;
    @(posedge clk) #1;
    x8 = a; y8 = b; in_valid8 = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
    is_signed8 = sgn;
`endif
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready8) break;
    end
    check("accept8", 32'(in_ready8), 32'd1);
    exp8.push_back(ref8(a, b, sgn));
    @(posedge clk) #1;
    in_valid8 = 1'b0;
    x8 = 8'($urandom); y8 = 8'($urandom);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    int t;
    @(posedge clk) #1;
    x16 = a; y16 = b; in_valid16 = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
    is_signed16 = sgn;
`endif
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready16) break;
    end
    check("accept16", 32'(in_ready16), 32'd1);
    exp16.push_back(ref16(a, b, sgn));
    @(posedge clk) #1;
    in_valid16 = 1'b0;
    x16 = 16'($urandom); y16 = 16'($urandom);
  endtask

  // Accept from IDLE and count edges from the accepting edge to out_valid.
  task automatic lat8(input logic [7:0] a, input logic [7:0] b, input logic sgn, input int exp_lat);
    int n;
    n = 0;
    @(posedge clk) #1;
    x8 = a; y8 = b; in_valid8 = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
    is_signed8 = sgn;
`endif
    @(negedge clk);
    check("ready_in_idle", 32'(in_ready8), 32'd1);
    exp8.push_back(ref8(a, b, sgn));
    @(posedge clk) #1;
    in_valid8 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid8) begin
        n = k;
        break;
      end
    end
    check("latency8", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int prev_outs;
    rst = 1'b1;
    in_valid8 = 1'b0; x8 = 8'd0; y8 = 8'd0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; x16 = 16'd0; y16 = 16'd0; out_ready16 = 1'b1;
`ifdef BOOTH_UNSIGNED_EN
    is_signed8 = 1'b1; is_signed16 = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_z8", 32'(z8), 32'd0);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_in_ready8", 32'(in_ready8), 32'd1);
    check("rst_in_ready16", 32'(in_ready16), 32'd1);
    check("rst_busy16", 32'(busy16), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Basic product and latency (ITER+1 = 5 for WIDTH=8).
    lat8(8'd3, 8'd5, 1'b1, 5);
    issue8(8'h80, 8'h80, 1'b1);   // -128 * -128 = 16384
    issue8(8'h7F, 8'h80, 1'b1);   //  127 * -128 = -16256
    issue8(8'hFF, 8'hFF, 1'b1);   //   -1 * -1
    issue8(8'h00, 8'h9C, 1'b1);

    // Stall in DONE for 10 cycles with a new (ignored) in_valid.
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready8) break;
    end
    @(posedge clk) #1;
    out_ready8 = 1'b0;
    issue8(8'hF9, 8'h09, 1'b1);   // -7 * 9 = -63
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid8) break;
    end
    check("stall_valid_seen", 32'(out_valid8), 32'd1);
    @(posedge clk) #1;
    in_valid8 = 1'b1; x8 = 8'd1; y8 = 8'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("stall_z8", 32'(z8), 32'h0000FFC1);
      check("stall_out_valid8", 32'(out_valid8), 32'd1);
      check("stall_in_ready8", 32'(in_ready8), 32'd0);
      check("stall_busy8", 32'(busy8), 32'd1);
      @(posedge clk) #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_out_valid8", 32'(out_valid8), 32'd0);
    check("release_in_ready8", 32'(in_ready8), 32'd1);

    // Reset during the second CALC cycle aborts the product.
    issue8(8'd5, 8'd6, 1'b1);     // returns just after the accepting edge
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_z8", 32'(z8), 32'd0);
    check("abort_out_valid8", 32'(out_valid8), 32'd0);
    check("abort_in_ready8", 32'(in_ready8), 32'd1);
    @(posedge clk) #1;
    rst = 1'b0;
    void'(exp8.pop_back());
    prev_outs = outs8;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("abort_no_output8", 32'(outs8), 32'(prev_outs));

`ifdef BOOTH_UNSIGNED_EN
    lat8(8'd255, 8'd255, 1'b0, 6);
    lat8(8'h80, 8'h80, 1'b1, 5);
`endif

    // Random back-to-back sweep with out_ready held high.
    fork
      begin
        for (int i = 0; i < 1000; i++) issue8(8'($urandom), 8'($urandom), 1'b1);
      end
      begin
        issue16(16'h8000, 16'h8000, 1'b1);
        issue16(16'h7FFF, 16'h8000, 1'b1);
        for (int i = 0; i < 1000; i++) issue16(16'($urandom), 16'($urandom), 1'b1);
      end
    join

    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp8.size() == 0 && exp16.size() == 0) break;
    end
    check("drain8", 32'(exp8.size()), 32'd0);
    check("drain16", 32'(exp16.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
